// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared state encodings, reset cause codes and helpers
// Cause codes are decoded by the core's I/O block, so their values are fixed.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    S_HOLD  = 2'b00,
    S_RUN   = 2'b01,
    S_PRESS = 2'b10
  } state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/reset_sequencer_debounce.sv
// rtl/reset_sequencer_debounce.sv - button synchroniser plus counting debounce filter
// LEVEL is the filtered active-low button level (1 = released).
module debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic CLK,
  input  logic RESn,
  input  logic IN_N,
  output logic LEVEL
);

  logic [SYNC_STAGES-1:0]   sync;
  logic [DEBOUNCE_BITS-1:0] cnt;
  logic                     stable;

  // The level only flips after the synchronised input has disagreed with it
  // for a full counter wrap; any agreeing sample restarts the window.
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      sync   <= '1;
      stable <= 1'b1;
      cnt    <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], IN_N};
      if (sync[SYNC_STAGES-1] == stable) begin
        cnt <= '0;
      end else if (&cnt) begin
        stable <= sync[SYNC_STAGES-1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + DEBOUNCE_BITS'(1);
      end
    end
  end

  assign LEVEL = stable;

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - board reset/boot sequencer with cause and count tracking
// Optional watchdog enabled by defining RESET_SEQUENCER_WDT_EN.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_BITS = 16,
  parameter int HOLD_CYCLES   = 64,
  parameter int WDT_BITS      = 24
) (
  input  logic       CLK,
  input  logic       RESn,
  input  logic       BTN_N,
  input  logic       WDT_KICK,
  output logic       CORE_RES,
  output logic       RUN,
  output logic       BTN_PRESSED,
  output logic [1:0] CAUSE,
  output logic [7:0] RST_CNT
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              level;
  logic              wdt_expire;
  logic [1:0]        cause_nxt;
  logic [7:0]        rst_cnt_nxt;

  debounce #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_debounce (
    .CLK  (CLK),
    .RESn (RESn),
    .IN_N (BTN_N),
    .LEVEL(level)
  );

  assign BTN_PRESSED = ~level;

`ifdef RESET_SEQUENCER_WDT_EN
  logic [WDT_BITS-1:0] wdt_cnt;

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      wdt_cnt <= '0;
    end else if (state != S_RUN || WDT_KICK) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + WDT_BITS'(1);
    end
  end

  assign wdt_expire = (state == S_RUN) && (&wdt_cnt) && !WDT_KICK;
`else
  assign wdt_expire = 1'b0;
  wire [WDT_BITS:0] unused_wdt = {WDT_KICK, {WDT_BITS{1'b0}}};
`endif

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state    <= S_HOLD;
      hold_cnt <= HOLD_INIT;
      CORE_RES <= 1'b1;
      RUN      <= 1'b0;
      CAUSE    <= CAUSE_POR;
      RST_CNT  <= 8'd0;
    end else begin
      state    <= state_nxt;
      CORE_RES <= (state_nxt != S_RUN);
      RUN      <= (state_nxt == S_RUN);
      CAUSE    <= cause_nxt;
      RST_CNT  <= rst_cnt_nxt;
      // Staying in S_HOLD implies the counter is non-zero; any other path reloads it.
      if (state == S_HOLD && state_nxt == S_HOLD) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end else begin
        hold_cnt <= HOLD_INIT;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HOLD: begin
        if (BTN_PRESSED) state_nxt = S_PRESS;
        else if (hold_cnt == '0) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (BTN_PRESSED) state_nxt = S_PRESS;
        else if (wdt_expire) state_nxt = S_HOLD;
      end
      S_PRESS: begin
        if (!BTN_PRESSED) state_nxt = S_HOLD;
      end
      default: state_nxt = S_HOLD;
    endcase
  end

  // Only an exit from S_RUN is a new reset event; re-presses during hold are not.
  always_comb begin
    cause_nxt   = CAUSE;
    rst_cnt_nxt = RST_CNT;
    if (state == S_RUN && state_nxt != S_RUN) begin
      cause_nxt   = BTN_PRESSED ? CAUSE_BTN : CAUSE_WDT;
      rst_cnt_nxt = sat_inc(RST_CNT);
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
// Watchdog steps run when RESET_SEQUENCER_WDT_EN is defined.
module tb_reset_sequencer;

  logic       CLK = 1'b0;
  logic       RESn;
  logic       btn_n, btn2_n, wdt_kick;
  logic       core_res, run, btn_pressed;
  logic [1:0] cause;
  logic [7:0] rst_cnt;
  logic       core_res2, run2, btn_pressed2;
  logic [1:0] cause2;
  logic [7:0] rst_cnt2;

  int checks = 0;
  int errors = 0;
  int n_cnt;
  int exp_cnt;
  logic seen;

  reset_sequencer #(
    .SYNC_STAGES(2), .DEBOUNCE_BITS(3), .HOLD_CYCLES(4), .WDT_BITS(5)
  ) dut (
    .CLK(CLK), .RESn(RESn), .BTN_N(btn_n), .WDT_KICK(wdt_kick),
    .CORE_RES(core_res), .RUN(run), .BTN_PRESSED(btn_pressed),
    .CAUSE(cause), .RST_CNT(rst_cnt)
  );

  reset_sequencer #(
    .SYNC_STAGES(2), .DEBOUNCE_BITS(3), .HOLD_CYCLES(16), .WDT_BITS(5)
  ) dut2 (
    .CLK(CLK), .RESn(RESn), .BTN_N(btn2_n), .WDT_KICK(1'b1),
    .CORE_RES(core_res2), .RUN(run2), .BTN_PRESSED(btn_pressed2),
    .CAUSE(cause2), .RST_CNT(rst_cnt2)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_btn(input int which, input logic want, input string tag);
    int n = 0;
    while (((which == 1) ? btn_pressed : btn_pressed2) !== want && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, (which == 1) ? btn_pressed : btn_pressed2, want);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    RESn = 1'b0; btn_n = 1'b1; btn2_n = 1'b1; wdt_kick = 1'b0;
    tick(3);
    chk("rst_core_res", core_res, 1);
    chk("rst_run", run, 0);
    chk("rst_btn_pressed", btn_pressed, 0);
    chk("rst_cause", cause, 0);
    chk("rst_cnt", rst_cnt, 0);
    chk("rst_core_res2", core_res2, 1);

    // POR: CORE_RES falls on the 4th edge after release
    RESn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("por_hold", core_res, 1);
    end
    tick(1);
    chk("por_core_res", core_res, 0);
    chk("por_run", run, 1);
    chk("por_cause", cause, 0);
    chk("por_cnt", rst_cnt, 0);

    // Glitch of 5 cycles is filtered out
    wdt_kick = 1'b1; btn_n = 1'b0; seen = 1'b0;
    tick(1);
    wdt_kick = 1'b0;
    seen = seen | btn_pressed | core_res;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      seen = seen | btn_pressed | core_res;
    end
    btn_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen = seen | btn_pressed | core_res;
    end
    chk("glitch_seen", seen, 0);
    chk("glitch_cnt", rst_cnt, 0);

    // Press 20 cycles: debounced after 10 edges, reset one edge later
    btn_n = 1'b0;
    tick(9);
    chk("press_early", btn_pressed, 0);
    tick(1);
    chk("press_debounced", btn_pressed, 1);
    chk("press_core_res_pre", core_res, 0);
    tick(1);
    chk("press_core_res", core_res, 1);
    chk("press_run", run, 0);
    chk("press_cause", cause, 1);
    chk("press_cnt", rst_cnt, 1);
    tick(9);
    btn_n = 1'b1;
    tick(9);
    chk("release_early", btn_pressed, 1);
    chk("held_cnt", rst_cnt, 1);
    tick(1);
    chk("release_debounced", btn_pressed, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("release_hold", core_res, 1);
    end
    tick(1);
    chk("release_core_res", core_res, 0);
    chk("release_run", run, 1);
    chk("release_cause", cause, 1);
    chk("release_cnt", rst_cnt, 1);

`ifdef RESET_SEQUENCER_WDT_EN
    // No kicks: RUN lasts 32 cycles, then a 4-cycle watchdog reset
    n_cnt = 0;
    for (int i = 0; i < 31; i++) begin
      tick(1);
      if (run) n_cnt++;
    end
    chk("wdt_run_len", n_cnt, 31);
    tick(1);
    chk("wdt_core_res", core_res, 1);
    chk("wdt_cause", cause, 2);
    chk("wdt_cnt", rst_cnt, 2);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("wdt_hold", core_res, 1);
    end
    tick(1);
    chk("wdt_release", core_res, 0);
    chk("wdt_release_run", run, 1);

    n_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 20 == 0) wdt_kick = 1'b1;
      tick(1);
      wdt_kick = 1'b0;
      if (!run) n_cnt++;
    end
    chk("wdt_kicked_drops", n_cnt, 0);

    wdt_kick = 1'b1;
    tick(1);
    wdt_kick = 1'b0;
    tick(31);
    chk("wdt_edge_run", run, 1);
    wdt_kick = 1'b1;
    tick(1);
    wdt_kick = 1'b0;
    chk("wdt_kick_on_expiry", run, 1);
    tick(5);
    chk("wdt_kick_on_expiry_late", run, 1);
    chk("wdt_kick_cause", cause, 2);
    chk("wdt_kick_cnt", rst_cnt, 2);
    exp_cnt = 2;
`else
    n_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (!run) n_cnt++;
    end
    chk("nowdt_drops", n_cnt, 0);
    chk("nowdt_cause", cause, 1);
    exp_cnt = 1;
`endif

    // Re-press during hold restarts the full 16-cycle hold on dut2
    btn2_n = 1'b0;
    wait_btn(2, 1, "d2_press");
    tick(1);
    chk("d2_core_res", core_res2, 1);
    chk("d2_cause", cause2, 1);
    chk("d2_cnt", rst_cnt2, 1);
    btn2_n = 1'b1;
    wait_btn(2, 0, "d2_release");
    tick(2);
    btn2_n = 1'b0;
    wait_btn(2, 1, "d2_repress");
    tick(1);
    chk("d2_repress_core_res", core_res2, 1);
    chk("d2_repress_cnt", rst_cnt2, 1);
    tick(8);
    chk("d2_still_reset", core_res2, 1);
    btn2_n = 1'b1;
    wait_btn(2, 0, "d2_release2");
    n_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (core_res2) n_cnt++;
    end
    chk("d2_hold_len", n_cnt, 16);
    tick(1);
    chk("d2_hold_end", core_res2, 0);
    chk("d2_run", run2, 1);
    chk("d2_final_cnt", rst_cnt2, 1);
    chk("d2_final_cause", cause2, 1);

    // Saturation over 260 presses
    for (int p = 0; p < 260; p++) begin
      btn_n = 1'b0;
      wait_btn(1, 1, "sat_press");
      btn_n = 1'b1;
      wait_btn(1, 0, "sat_release");
      tick(6);
      exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
      if (p == 99) chk("sat_mid_cnt", rst_cnt, exp_cnt);
    end
    chk("sat_cnt", rst_cnt, 255);
    chk("sat_cause", cause, 1);
    chk("sat_run", run, 1);

    // Async reset in the middle of S_HOLD
    btn_n = 1'b0;
    wait_btn(1, 1, "async_press");
    btn_n = 1'b1;
    wait_btn(1, 0, "async_release");
    tick(2);
    chk("async_in_hold", core_res, 1);
    #2 RESn = 1'b0;
    #1;
    chk("async_core_res", core_res, 1);
    chk("async_run", run, 0);
    chk("async_btn", btn_pressed, 0);
    chk("async_cause", cause, 0);
    chk("async_cnt", rst_cnt, 0);
    chk("async_core_res2", core_res2, 1);
    chk("async_cnt2", rst_cnt2, 0);
    tick(1);
    RESn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("repor_hold", core_res, 1);
    end
    tick(1);
    chk("repor_core_res", core_res, 0);
    chk("repor_run", run, 1);

    // Async reset while running drops RUN before any clock edge
    #2 RESn = 1'b0;
    #1;
    chk("async_run_core_res", core_res, 1);
    chk("async_run_run", run, 0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Board-level reset and boot sequencer between the MAX1000 clock/button pins and the darkriscv core plus its peripherals.
- Filters the raw active-low user button and stretches every reset request to a guaranteed minimum width.
- Drives the core's synchronous active-high reset and records the cause and count of resets.
- Optionally runs a software-kicked watchdog that re-sequences the core on timeout.

Parameters:
SYNC_STAGES, 2, flops in the button synchroniser (>=2)
DEBOUNCE_BITS, 16, debounce counter width; filter time 2^DEBOUNCE_BITS cycles (~5.5 ms at 12 MHz)
HOLD_CYCLES, 64, minimum CORE_RES assertion length in cycles (>=1)
WDT_BITS, 24, watchdog counter width; timeout 2^WDT_BITS-1 cycles

Ports:
CLK  in  1  system clock (12 MHz board clock)
RESn  in  1  asynchronous active-low reset (POR / PLL locked)
BTN_N  in  1  raw user button, active low, asynchronous to CLK
WDT_KICK  in  1  single-cycle watchdog restart strobe from core I/O
CORE_RES  out  1  synchronous active-high reset to core/peripherals
RUN  out  1  high while state is S_RUN
BTN_PRESSED  out  1  debounced button level, 1 = pressed
CAUSE  out  2  last reset cause: 00 POR, 01 button, 10 watchdog, 11 reserved
RST_CNT  out  8  count of non-POR resets, saturating at 255

Behaviour:
- Reset (RESn low, async):
  - Synchroniser flops all 1; debounced level 1 (released); debounce counter 0.
  - State S_HOLD, hold counter HOLD_CYCLES-1, watchdog counter 0.
  - CORE_RES=1, RUN=0, BTN_PRESSED=0, CAUSE=00, RST_CNT=0.
- Synchroniser: BTN_N through SYNC_STAGES flops.
- Debounce:
  - Counter clears when sync == stable level.
  - Otherwise it increments.
  - When it reaches all-ones with sync still different, stable <= sync and counter clears.
  - BTN_PRESSED = ~stable, registered.
  - Glitches shorter than 2^DEBOUNCE_BITS cycles never change BTN_PRESSED.
- FSM (registered outputs):
  - S_HOLD: CORE_RES=1.
    - BTN_PRESSED=1 -> S_PRESS.
    - Else if hold counter==0 -> S_RUN with CORE_RES=0.
    - Else hold counter decrements.
  - S_RUN: CORE_RES=0, RUN=1.
    - BTN_PRESSED=1 -> S_PRESS; CAUSE<=01; RST_CNT++.
  - S_PRESS: CORE_RES=1, RUN=0; hold counter held at HOLD_CYCLES-1.
    - BTN_PRESSED=0 -> S_HOLD.
- Latency:
  - After RESn rises, CORE_RES falls on the HOLD_CYCLES-th rising edge.
  - After button release is debounced, CORE_RES falls HOLD_CYCLES+1 edges later.
  - RUN tracks ~CORE_RES exactly.
- Boundaries:
  - Button held indefinitely: core stays in reset; no count increment while held.
  - Press during S_HOLD: re-enters S_PRESS and restarts the full hold; CAUSE/RST_CNT are not incremented again.
  - RST_CNT saturates at 255; only RESn clears it.
  - RESn mid-sequence: immediate async return to reset values, CAUSE=00.

Optional Feature:
Macro: RESET_SEQUENCER_WDT_EN.
- With macro defined:
  - The watchdog counter is active only in S_RUN and increments each cycle.
  - WDT_KICK clears it to 0.
  - On reaching all-ones: -> S_HOLD with hold counter reload, CORE_RES=1 next edge, CAUSE<=10, RST_CNT++.
  - The counter clears in every other state.
  - Same-cycle priority: kick beats expiry; button press beats expiry (CAUSE=01).
- Without macro:
  - The WDT_KICK port remains but is ignored.
  - No watchdog logic is synthesised; CAUSE is never 10.

Decomposition:
- Shared include (config.vh style): state encodings S_HOLD/S_RUN/S_PRESS and cause codes CAUSE_POR/CAUSE_BTN/CAUSE_WDT, so the core's I/O block can decode CAUSE.
- Sub-module `debounce`: synchroniser plus filter, parameters SYNC_STAGES and DEBOUNCE_BITS, ports CLK, RESn, IN_N, LEVEL.
- FSM, counters and watchdog stay in reset_sequencer.

Test Plan:
(All tests use DEBOUNCE_BITS=3, HOLD_CYCLES=4, WDT_BITS=5.)
- POR: RESn low 3 cycles then high, button idle -> CORE_RES=1 for exactly 4 edges, then 0; RUN=1, CAUSE=00, RST_CNT=0.
- Glitch: BTN_N low for 5 cycles in S_RUN -> BTN_PRESSED stays 0, CORE_RES stays 0, RST_CNT=0.
- Press: BTN_N low 20 cycles then high -> BTN_PRESSED rises 2+8 cycles after fall; CORE_RES=1 one edge later; CORE_RES falls 5 edges after debounced release; CAUSE=01, RST_CNT=1.
- Re-press during S_HOLD: second debounced press 2 cycles into hold -> back to S_PRESS, full 4-cycle hold restarts, RST_CNT still 1.
- Watchdog (macro on): no kicks in S_RUN -> expiry after 31 cycles, CORE_RES=1 for 4 cycles, CAUSE=10, RST_CNT=1. Kick every 20 cycles -> no reset. Kick on expiry cycle -> no reset.
- Saturation and async reset: 260 presses -> RST_CNT=255. Assert RESn mid-S_HOLD -> all outputs return to reset values immediately, without waiting for a clock edge.
